// File: rtl/cache_range_maint.sv
// cache_range_maint: walks a set range of the D$ and cleans, flushes or invalidates each line,
// writing dirty lines back over a req/ack bus.
module cache_range_maint #(
  parameter int PA_BITS   = 56,
  parameter int NUMLINES  = 128,
  parameter int NUMWAYS   = 4,
  parameter int OFFSETLEN = 6,
  parameter int SETLEN    = $clog2(NUMLINES),
  parameter int TAGLEN    = PA_BITS - SETLEN - OFFSETLEN,
  parameter int CNTW      = SETLEN + $clog2(NUMWAYS) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [1:0]           Mode,
  input  logic [SETLEN-1:0]    SetLo,
  input  logic [SETLEN-1:0]    SetHi,
  output logic                 Busy,
  output logic                 Done,
  output logic                 ArrayRdEn,
  output logic [SETLEN-1:0]    ArraySet,
  output logic [NUMWAYS-1:0]   ArrayWay,
  input  logic                 ValidIn,
  input  logic                 DirtyIn,
  input  logic [TAGLEN-1:0]    TagIn,
  output logic                 ClearDirty,
  output logic                 ClearValid,
  output logic                 BusReq,
  output logic [PA_BITS-1:0]   BusAdr,
  input  logic                 BusAck,
  output logic [CNTW-1:0]      LinesWritten
);
  typedef enum logic [2:0] {IDLE, READ, CHECK, WB, UPDATE, ADVANCE, DONE} state_t;
  state_t r_state, w_next;
  logic [1:0]         r_mode;
  logic [SETLEN-1:0]  r_set, r_hi;
  logic [NUMWAYS-1:0] r_way;
  logic [TAGLEN-1:0]  r_tag;
  logic               r_wb;
  logic [CNTW-1:0]    r_cnt;
  logic               w_last;
  // termination is tested before the set counter moves, so SetHi = NUMLINES-1 never wraps
  assign w_last = r_way[NUMWAYS-1] && (r_set == r_hi);
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !Start ? IDLE : (SetLo > SetHi) ? DONE : READ;
      READ:    w_next = CHECK;
      CHECK:   w_next = !ValidIn ? ADVANCE : (r_mode == 2'd2) ? UPDATE :
                        DirtyIn ? WB : (r_mode == 2'd1) ? UPDATE : ADVANCE;
      WB:      w_next = BusAck ? UPDATE : WB;
      UPDATE:  w_next = ADVANCE;
      ADVANCE: w_next = w_last ? DONE : READ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_mode <= 2'd0;
      r_set  <= '0;
      r_hi   <= '0;
      r_way  <= NUMWAYS'(1);
      r_tag  <= '0;
      r_wb   <= 1'b0;
      r_cnt  <= '0;
    end else
      case (r_state)
        IDLE: if (Start) begin
          r_mode <= (Mode == 2'd3) ? 2'd0 : Mode;
          r_set  <= SetLo;
          r_hi   <= SetHi;
          r_way  <= NUMWAYS'(1);
          r_cnt  <= '0;
        end
        CHECK: begin
          r_tag <= TagIn;
          r_wb  <= 1'b0;
        end
        WB: if (BusAck) begin
          r_cnt <= r_cnt + 1'b1;
          r_wb  <= 1'b1;
        end
        ADVANCE: if (!w_last) begin
          r_way <= r_way[NUMWAYS-1] ? NUMWAYS'(1) : r_way << 1;
          if (r_way[NUMWAYS-1]) r_set <= r_set + 1'b1;
        end
        default: ;
      endcase
  assign Busy         = r_state != IDLE;
  assign Done         = r_state == DONE;
  assign ArrayRdEn    = r_state == READ;
  assign ArraySet     = r_set;
  assign ArrayWay     = r_way;
  assign ClearDirty   = (r_state == UPDATE) && r_wb;
  assign ClearValid   = (r_state == UPDATE) && (r_mode != 2'd0);
  assign BusReq       = r_state == WB;
  assign BusAdr       = (r_state == WB) ? {r_tag, r_set, {OFFSETLEN{1'b0}}} : '0;
  assign LinesWritten = r_cnt;
endmodule

// File: tb/tb_cache_range_maint.sv
// tb_cache_range_maint: drives range operations against a small tag/state array model and
// compares writebacks, clears, cycle counts and counters with a reference walk of the range.
module tb_cache_range_maint;
  localparam int PA_BITS = 56, NL = 8, NW = 2, OFS = 6, SL = 3, TL = PA_BITS - SL - OFS, CW = SL + 1 + 1;
  logic clk = 1'b0, reset = 1'b0, Start = 1'b0, BusAck = 1'b0;
  logic [1:0] Mode = 2'd0;
  logic [SL-1:0] SetLo = '0, SetHi = '0;
  logic Busy, Done, ArrayRdEn, ValidIn, DirtyIn, ClearDirty, ClearValid, BusReq;
  logic [SL-1:0] ArraySet;
  logic [NW-1:0] ArrayWay;
  logic [TL-1:0] TagIn;
  logic [PA_BITS-1:0] BusAdr;
  logic [CW-1:0] LinesWritten;
  logic mem_v [NL][NW];
  logic mem_d [NL][NW];
  logic [TL-1:0] mem_t [NL][NW];
  typedef struct {logic [1:0] kind; logic [63:0] data;} ev_t;
  typedef struct {logic [1:0] m; int lo; int hi; int ack; bit poke;} vec_t;
  ev_t exp_q[$];
  vec_t tv[5];
  int n_run = 0, n_fail = 0;

  cache_range_maint #(.PA_BITS(PA_BITS), .NUMLINES(NL), .NUMWAYS(NW), .OFFSETLEN(OFS)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Mode(Mode), .SetLo(SetLo), .SetHi(SetHi),
    .Busy(Busy), .Done(Done), .ArrayRdEn(ArrayRdEn), .ArraySet(ArraySet), .ArrayWay(ArrayWay),
    .ValidIn(ValidIn), .DirtyIn(DirtyIn), .TagIn(TagIn), .ClearDirty(ClearDirty),
    .ClearValid(ClearValid), .BusReq(BusReq), .BusAdr(BusAdr), .BusAck(BusAck),
    .LinesWritten(LinesWritten));

  always #5 clk = ~clk;
  assign ValidIn = mem_v[ArraySet][ArrayWay[1]];
  assign DirtyIn = mem_d[ArraySet][ArrayWay[1]];
  assign TagIn   = mem_t[ArraySet][ArrayWay[1]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_ev(input string name, input logic [1:0] kind, input logic [63:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk({name, "_unexpected"}, {kind, data[61:0]}, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_kind"}, 64'(kind), 64'(e.kind));
      chk({name, "_data"}, data, e.data);
    end
  endtask

  task automatic clear_mem();
    for (int s = 0; s < NL; s++)
      for (int w = 0; w < NW; w++) begin
        mem_v[s][w] = 1'b0;
        mem_d[s][w] = 1'b0;
        mem_t[s][w] = '0;
      end
  endtask

  task automatic rand_mem();
    for (int s = 0; s < NL; s++)
      for (int w = 0; w < NW; w++) begin
        mem_v[s][w] = 1'($urandom_range(0, 1));
        mem_d[s][w] = 1'($urandom_range(0, 1));
        mem_t[s][w] = TL'({$urandom, $urandom});
      end
  endtask

  task automatic run_op(input string name, input logic [1:0] m, input int lo, input int hi,
                        input int ack, input bit poke);
    int cyc = 0, reads = 0, req = 0, exp_cyc = 1, exp_reads = 0, exp_wr = 0;
    bit done = 0;
    logic [1:0] mm;
    mm = (m == 2'd3) ? 2'd0 : m;
    exp_q.delete();
    for (int s = lo; s <= hi; s++)
      for (int w = 0; w < NW; w++) begin
        exp_reads++;
        if (!mem_v[s][w]) exp_cyc += 3;
        else if (mm == 2'd2 || (!mem_d[s][w] && mm == 2'd1)) begin
          exp_cyc += 4;
          exp_q.push_back('{2'd2, 64'({3'(s), 2'(1 << w), 1'b0, 1'b1})});
        end else if (mem_d[s][w]) begin
          exp_cyc += 4 + ack;
          exp_wr++;
          exp_q.push_back('{2'd1, 64'({mem_t[s][w], 3'(s), 6'b0})});
          exp_q.push_back('{2'd2, 64'({3'(s), 2'(1 << w), 1'b1, mm == 2'd1})});
        end else exp_cyc += 3;
      end
    @(negedge clk);
    Start = 1'b1; Mode = m; SetLo = SL'(lo); SetHi = SL'(hi);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      Start = 1'b0;
      if (poke && cyc == 2) begin
        Start = 1'b1; Mode = 2'd2; SetLo = '0; SetHi = SL'(NL - 1);
      end
      if (ArrayRdEn) reads++;
      if (BusReq) begin
        req++;
        if (req == 1) chk_ev({name, "_bus"}, 2'd1, 64'(BusAdr));
        BusAck = (req == ack);
      end else begin
        req = 0;
        BusAck = 1'b0;
      end
      if (ClearDirty || ClearValid) begin
        chk_ev({name, "_clr"}, 2'd2, 64'({ArraySet, ArrayWay, ClearDirty, ClearValid}));
        if (ClearDirty) mem_d[ArraySet][ArrayWay[1]] = 1'b0;
        if (ClearValid) mem_v[ArraySet][ArrayWay[1]] = 1'b0;
      end
      if (Done) begin
        done = 1;
        chk({name, "_busy_at_done"}, 64'(Busy), 64'd1);
        chk({name, "_lines_written"}, 64'(LinesWritten), 64'(exp_wr));
      end
    end
    Start = 1'b0;
    chk({name, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({name, "_reads"}, 64'(reads), 64'(exp_reads));
    chk({name, "_events_left"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk({name, "_idle_after"}, 64'({Busy, Done}), 64'd0);
    chk({name, "_lw_hold"}, 64'(LinesWritten), 64'(exp_wr));
  endtask

  initial begin
    int cyc;
    tv[0] = '{2'd0, 0, 7, 1, 1'b0};
    tv[1] = '{2'd1, 2, 7, 3, 1'b1};
    tv[2] = '{2'd2, 0, 4, 1, 1'b0};
    tv[3] = '{2'd3, 6, 7, 2, 1'b1};
    tv[4] = '{2'd1, 7, 7, 1, 1'b0};
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({Busy, Done, ArrayRdEn, ClearDirty, ClearValid, BusReq}), 64'd0);
    chk("rst_set", 64'(ArraySet), 64'd0);
    chk("rst_way", 64'(ArrayWay), 64'd1);
    chk("rst_adr", 64'(BusAdr), 64'd0);
    chk("rst_lw", 64'(LinesWritten), 64'd0);
    reset = 1'b1;
    run_op("all_invalid", 2'd0, 0, 7, 2, 1'b0);
    mem_v[3][1] = 1'b1; mem_d[3][1] = 1'b1; mem_t[3][1] = TL'(12'h012);
    run_op("clean_one", 2'd0, 3, 3, 2, 1'b0);
    mem_d[3][1] = 1'b1;
    mem_v[4][0] = 1'b1; mem_d[4][0] = 1'b0; mem_t[4][0] = TL'(12'h345);
    run_op("flush_two", 2'd1, 3, 4, 3, 1'b0);
    mem_v[3][1] = 1'b1; mem_d[3][1] = 1'b1;
    run_op("inval_dirty", 2'd2, 3, 3, 2, 1'b0);
    run_op("lo_gt_hi", 2'd0, 5, 2, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      rand_mem();
      run_op($sformatf("vec%0d", i), tv[i].m, tv[i].lo, tv[i].hi, tv[i].ack, tv[i].poke);
    end
    clear_mem();
    mem_v[2][0] = 1'b1; mem_d[2][0] = 1'b1; mem_t[2][0] = TL'(12'h777);
    @(negedge clk);
    Start = 1'b1; Mode = 2'd1; SetLo = 3'd2; SetHi = 3'd2;
    cyc = 0;
    do begin
      @(negedge clk);
      Start = 1'b0;
      cyc++;
    end while (!BusReq && cyc < 50);
    chk("mid_busreq", 64'(BusReq), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busreq", 64'(BusReq), 64'd0);
    chk("mid_rst_busy", 64'(Busy), 64'd0);
    cyc = 0;
    repeat (3) begin
      @(negedge clk);
      if (ClearDirty || ClearValid || BusReq) cyc++;
    end
    chk("mid_rst_quiet", 64'(cyc), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle", 64'({Busy, ArraySet, ArrayWay, LinesWritten}), 64'({1'b0, 3'd0, 2'd1, 5'd0}));
    run_op("after_rst", 2'd1, 0, 7, 2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cache_range_maint.md
Name: cache_range_maint

Overview:
- Parametrised cache maintenance engine for the D$.
- Generalises the whole-cache flush counter into a programmable set range with three modes: clean, flush and invalidate.
- Skips lines that are invalid or clean, writes dirty lines back over a req/ack bus handshake, and counts writebacks.
- Sits beside the cache array and cachefsm. It owns array set/way selection and the bus writeback request while Busy.

Parameters:
PA_BITS, 56, physical address width
NUMLINES, 128, sets per way (power of 2, >=2)
NUMWAYS, 4, ways (>=1)
OFFSETLEN, 6, log2 line bytes
TAGLEN, PA_BITS-$clog2(NUMLINES)-OFFSETLEN, tag width
SETLEN, $clog2(NUMLINES), set index width (derived)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
Start  in  1  begin operation (sampled in IDLE only)
Mode  in  2  0 clean, 1 flush (clean+invalidate), 2 invalidate-discard, 3 reserved
SetLo  in  SETLEN  first set (inclusive)
SetHi  in  SETLEN  last set (inclusive)
Busy  out  1  engine active (not IDLE)
Done  out  1  one-cycle completion pulse
ArrayRdEn  out  1  read request to tag/state arrays
ArraySet  out  SETLEN  set being visited
ArrayWay  out  NUMWAYS  one-hot way being visited
ValidIn  in  1  valid bit of ArraySet/ArrayWay, one cycle after ArrayRdEn
DirtyIn  in  1  dirty bit, same timing
TagIn  in  TAGLEN  tag, same timing
ClearDirty  out  1  clear dirty of ArraySet/ArrayWay this cycle
ClearValid  out  1  clear valid of ArraySet/ArrayWay this cycle
BusReq  out  1  writeback request
BusAdr  out  PA_BITS  {tag, set, OFFSETLEN zeros}
BusAck  in  1  writeback complete
LinesWritten  out  SETLEN+$clog2(NUMWAYS)+1  writebacks in current/last operation

Behaviour:
- Reset (reset=0, async): state IDLE. Busy, Done, ArrayRdEn, ClearDirty, ClearValid and BusReq are 0. ArraySet=0, ArrayWay=1, BusAdr=0, LinesWritten=0.
- A reset mid-operation abandons the operation: BusReq drops immediately and no clear is issued.
- States: IDLE, READ, CHECK, WB, UPDATE, ADVANCE, DONE.
- IDLE, Start=1:
  - Latch Mode, SetLo, SetHi. Mode 3 latches as 0.
  - Set counter=SetLo, way=1, LinesWritten=0.
  - If SetLo>SetHi, go to DONE with no array access. Otherwise go to READ.
- IDLE, Start=0: stay in IDLE.
- Start outside IDLE is ignored.
- READ: ArrayRdEn=1 for the current set/way. Next state CHECK.
- CHECK: register TagIn. Branch on ValidIn, DirtyIn and Mode:
  - ValidIn=0 -> ADVANCE.
  - Valid, dirty, Mode 0/1 -> WB.
  - Valid, Mode 2 -> UPDATE. Dirty data is discarded.
  - Valid, clean, Mode 1 -> UPDATE.
  - Valid, clean, Mode 0 -> ADVANCE.
- WB: BusReq=1 and BusAdr={registered tag, set, 0}, both held stable until BusAck. On BusAck: LinesWritten+1, go to UPDATE. BusAck outside WB is ignored.
- UPDATE: single cycle, then ADVANCE.
  - ClearDirty=1 if a writeback occurred in WB.
  - ClearValid=1 if Mode 1/2.
- ADVANCE:
  - If way is the last way and set==SetHi -> DONE.
  - Else rotate way left. When way wraps to 1, set+1. Then READ.
  - Compare before incrementing, so SetHi=NUMLINES-1 terminates without counter wrap.
- DONE: Done=1 for one cycle, then IDLE. LinesWritten holds until the next Start.
- Busy=1 in every state except IDLE.
- ArraySet/ArrayWay are stable from READ through UPDATE.
- Cycle cost per line:
  - Skipped: 3 (READ, CHECK, ADVANCE).
  - Invalidate-only: 4.
  - Writeback: 4 + bus cycles.
- Whole operation adds 1 cycle (DONE) after the last ADVANCE.
- LinesWritten cannot overflow (max NUMLINES*NUMWAYS).

Test Plan:
- NUMLINES=8, NUMWAYS=2, all lines invalid, Start Mode0 SetLo=0 SetHi=7 -> 16 READs, no BusReq/Clear*, Done at cycle 49 after Start, LinesWritten=0.
- Set3 way1 valid+dirty tag 0x12, Mode0 range 3..3, BusAck 2 cycles after BusReq -> BusAdr={0x12,3,0}, one ClearDirty on set3/way1, no ClearValid, LinesWritten=1.
- Same line, Mode1 -> writeback then ClearDirty=1 and ClearValid=1 in the same cycle. A valid clean line in range gets ClearValid only.
- Mode2 on dirty line -> no BusReq, ClearValid=1, ClearDirty=0, LinesWritten=0.
- SetLo=5 SetHi=2 -> Done one cycle after DONE entry, ArrayRdEn never asserted. Start=1 pulsed while Busy -> ignored, range unchanged.
- reset=0 asserted while BusReq=1 -> BusReq, Busy=0 asynchronously, state IDLE, no Clear* issued. Range SetHi=7 (max) completes without hang.
